// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus transfer arbiter: FSM state encoding,
// default widths, and the index-to-one-hot decode with range check.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int NSEL_DEFAULT = 20;
  localparam int IDXW_DEFAULT = 5;

  // Returns all-zero when idx >= nsel, so callers can test "== 0" for range errors.
  function automatic logic [63:0] idx_to_oh(input logic [31:0] idx, input int unsigned nsel);
    logic [63:0] oh;
    oh = '0;
    if ((idx < 32'(nsel)) && (idx < 32'd64)) oh[idx[5:0]] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_transfer_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i,
// where eligible means requesting and not masked by excl_i.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  input  logic [NREQ-1:0] excl_i,
  output logic [NREQ-1:0] win_oh_o,
  output logic            valid_o
);

  logic [NREQ-1:0] elig;
  assign elig = req_i & ~excl_i;

  always_comb begin
    int j;
    j        = 0;
    win_oh_o = '0;
    valid_o  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (!valid_o && elig[j]) begin
        win_oh_o[j] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_transfer_arbiter.sv
// Round-robin owner of the shared processor bus: runs a DRIVE/WRITE sequence
// per granted transfer and is the sole driver of the tri-state and write-enable one-hots.
module bus_transfer_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int NSEL     = NSEL_DEFAULT,
  parameter int IDXW     = IDXW_DEFAULT,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ*IDXW-1:0] src_idx,
  input  logic [NREQ*IDXW-1:0] dst_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [NSEL-1:0]      tri_controller_OH,
  output logic [NSEL-1:0]      r_en_OH,
  output logic                 busy,
  output state_e               dbg_state
);

  // Handshake: req is a level held until ack; each grant ends in exactly one
  // ack pulse to the owner. Dropping req or changing indices after gnt does not cancel it.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic [NSEL-1:0] tri_q, tri_d, ren_q, ren_d, dst_oh_q, dst_oh_d;
  logic            bad_q, bad_d, err_q, err_d, busy_q, busy_d;

  logic [NREQ-1:0] excl, win_oh;
  logic            win_valid, lock_cont, grant;
  logic [PW-1:0]   win_idx, cap_idx;
  logic [63:0]     cap_src_w, cap_dst_w;

  assign excl = (state_q == ST_WRITE) ? gnt_q : '0;

  rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .excl_i   (excl),
    .win_oh_o (win_oh),
    .valid_o  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) if (win_oh[i]) win_idx = PW'(i);
  end

  assign lock_cont = (state_q == ST_WRITE) && lock[owner_q] && req[owner_q] &&
                     (lock_cnt_q < CW'(MAX_LOCK));
  assign cap_idx   = lock_cont ? owner_q : win_idx;
  assign cap_src_w = idx_to_oh(32'(src_idx[cap_idx*IDXW +: IDXW]), NSEL);
  assign cap_dst_w = idx_to_oh(32'(dst_idx[cap_idx*IDXW +: IDXW]), NSEL);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    gnt_d      = gnt_q;
    tri_d      = tri_q;
    dst_oh_d   = dst_oh_q;
    bad_d      = bad_q;
    busy_d     = busy_q;
    ren_d      = '0;
    ack_d      = '0;
    err_d      = 1'b0;
    grant      = 1'b0;
    case (state_q)
      ST_IDLE: grant = win_valid;
      ST_DRIVE: begin
        state_d = ST_WRITE;
        ren_d   = dst_oh_q;
        ack_d   = gnt_q;
        err_d   = bad_q;
      end
      ST_WRITE: begin
        if (lock_cont || win_valid) begin
          grant = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          tri_d    = '0;
          dst_oh_d = '0;
          bad_d    = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d        = ST_DRIVE;
      busy_d         = 1'b1;
      owner_d        = cap_idx;
      gnt_d          = '0;
      gnt_d[cap_idx] = 1'b1;
      tri_d          = cap_src_w[NSEL-1:0];
      dst_oh_d       = cap_dst_w[NSEL-1:0];
      bad_d          = (cap_src_w == '0) || (cap_dst_w == '0);
      // A locked continuation keeps the pointer; a new owner moves it past itself.
      if (lock_cont) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end else begin
        lock_cnt_d = CW'(1);
        ptr_d      = (cap_idx == PW'(NREQ - 1)) ? '0 : cap_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      tri_q      <= '0;
      ren_q      <= '0;
      dst_oh_q   <= '0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      tri_q      <= tri_d;
      ren_q      <= ren_d;
      dst_oh_q   <= dst_oh_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt               = gnt_q;
  assign ack               = ack_q;
  assign err               = err_q;
  assign tri_controller_OH = tri_q;
  assign r_en_OH           = ren_q;
  assign busy              = busy_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Directed bench for bus_transfer_arbiter: hand-computed expected values for
// single transfer, round-robin, lock limit, range error, late changes and reset.
module tb_bus_transfer_arbiter;
  import bus_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int NSEL = 20;
  localparam int IDXW = 5;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req, lock, gnt, ack;
  logic [NREQ*IDXW-1:0] src_idx, dst_idx;
  logic                 err, busy;
  logic [NSEL-1:0]      tri_oh, ren_oh;
  state_e               dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  bus_transfer_arbiter #(.NREQ(NREQ), .NSEL(NSEL), .IDXW(IDXW), .MAX_LOCK(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req),
    .lock              (lock),
    .src_idx           (src_idx),
    .dst_idx           (dst_idx),
    .gnt               (gnt),
    .ack               (ack),
    .err               (err),
    .tri_controller_OH (tri_oh),
    .r_en_OH           (ren_oh),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idx(input int i, input int s, input int d);
    src_idx[i*IDXW +: IDXW] = IDXW'(s);
    dst_idx[i*IDXW +: IDXW] = IDXW'(d);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    lock    = '0;
    src_idx = '0;
    dst_idx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_ack"}, 32'(ack), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_tri"}, 32'(tri_oh), 32'h0);
    check({tag, "_ren"}, 32'(ren_oh), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    int owner;

    // reset values
    do_reset();
    check_quiet("rst");

    // single transfer: requester 2, src 3 -> dst 7
    tick();
    req = 4'b0100;
    set_idx(2, 3, 7);
    tick();
    check("t1_drive_gnt", 32'(gnt), 32'h4);
    check("t1_drive_tri", 32'(tri_oh), 32'h8);
    check("t1_drive_ren", 32'(ren_oh), 32'h0);
    check("t1_drive_ack", 32'(ack), 32'h0);
    check("t1_drive_busy", 32'(busy), 32'h1);
    req = '0;
    tick();
    check("t1_write_tri", 32'(tri_oh), 32'h8);
    check("t1_write_ren", 32'(ren_oh), 32'h80);
    check("t1_write_ack", 32'(ack), 32'h4);
    check("t1_write_err", 32'(err), 32'h0);
    tick();
    check_quiet("t1_after");

    // round-robin with all four requesting, no lock: 0,1,2,3,0 back to back
    do_reset();
    for (int i = 0; i < NREQ; i++) set_idx(i, i + 1, i + 10);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      owner = k % NREQ;
      tick();
      check("rr_gnt", 32'(gnt), 32'(1) << owner);
      check("rr_drive_tri", 32'(tri_oh), 32'(1) << (owner + 1));
      check("rr_drive_ren", 32'(ren_oh), 32'h0);
      check("rr_busy", 32'(busy), 32'h1);
      tick();
      check("rr_ack", 32'(ack), 32'(1) << owner);
      check("rr_write_ren", 32'(ren_oh), 32'(1) << (owner + 10));
    end
    req = '0;
    tick();
    check_quiet("rr_after");

    // lock: requester 1 keeps the bus four transfers, then requester 0 wins
    do_reset();
    set_idx(1, 4, 5);
    set_idx(0, 6, 8);
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    check("lk_first_gnt", 32'(gnt), 32'h2);
    req = 4'b0011;
    for (int t = 0; t < 4; t++) begin
      tick();
      check("lk_ack1", 32'(ack), 32'h2);
      check("lk_ren1", 32'(ren_oh), 32'h20);
      tick();
      if (t < 3) check("lk_keep_gnt", 32'(gnt), 32'h2);
      else       check("lk_handoff_gnt", 32'(gnt), 32'h1);
    end
    check("lk_handoff_tri", 32'(tri_oh), 32'h40);
    tick();
    check("lk_ack0", 32'(ack), 32'h1);
    check("lk_ren0", 32'(ren_oh), 32'h100);
    req  = '0;
    lock = '0;
    tick();
    check_quiet("lk_after");

    // out-of-range indices: still acks, err pulses, one-hots stay zero
    do_reset();
    set_idx(0, 25, 31);
    req = 4'b0001;
    tick();
    check("oor_gnt", 32'(gnt), 32'h1);
    check("oor_drive_tri", 32'(tri_oh), 32'h0);
    check("oor_drive_err", 32'(err), 32'h0);
    req = '0;
    tick();
    check("oor_ack", 32'(ack), 32'h1);
    check("oor_err", 32'(err), 32'h1);
    check("oor_write_tri", 32'(tri_oh), 32'h0);
    check("oor_write_ren", 32'(ren_oh), 32'h0);
    tick();
    check("oor_err_clear", 32'(err), 32'h0);
    check("oor_ack_clear", 32'(ack), 32'h0);

    // late change of dst and dropped req after grant do not alter the transfer
    do_reset();
    set_idx(0, 2, 9);
    req = 4'b0001;
    tick();
    check("late_gnt", 32'(gnt), 32'h1);
    req = '0;
    set_idx(0, 2, 12);
    tick();
    check("late_ack", 32'(ack), 32'h1);
    check("late_ren", 32'(ren_oh), 32'h200);
    check("late_tri", 32'(tri_oh), 32'h4);

    // asynchronous reset during DRIVE, then requester 0 has priority again
    do_reset();
    set_idx(2, 1, 2);
    req = 4'b0100;
    tick();
    check("ar_pre_gnt", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("ar_async");
    req = 4'b1101;
    set_idx(0, 3, 4);
    set_idx(3, 5, 6);
    @(negedge clk);
    check("ar_held_ren", 32'(ren_oh), 32'h0);
    rst_n = 1'b1;
    tick();
    check("ar_post_gnt", 32'(gnt), 32'h1);
    check("ar_post_tri", 32'(tri_oh), 32'h8);
    check("ar_post_ren", 32'(ren_oh), 32'h0);
    req = '0;
    tick();
    check("ar_post_ack", 32'(ack), 32'h1);
    check("ar_post_wren", 32'(ren_oh), 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_transfer_arbiter.md
# bus_transfer_arbiter

Sequences register-to-register transfers on the shared 16-bit processor bus and shares that bus among several requesters (instruction controller, program loader, PC, debug port). Each requester asks for one transfer as a source index and a destination index. The block grants the bus round-robin and drives the datapath's one-hot tri-state select (`tri_controller_OH`) and one-hot register write enable (`r_en_OH`) through a two-cycle drive/write sequence. It sits between the requesters and the datapath; it is the only driver of those two one-hot buses.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; index 0 has highest priority after reset.
- `NSEL`, 20, width of the one-hot tri-state and write-enable buses.
- `IDXW`, 5, width of one source or destination index.
- `MAX_LOCK`, 4, maximum consecutive transfers one locked owner may keep.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NREQ: per-requester transfer request, level.
- `lock` input NREQ: per-requester request to keep the bus for the next transfer.
- `src_idx` input NREQ*IDXW: packed source register index; requester i uses bits [i*IDXW +: IDXW].
- `dst_idx` input NREQ*IDXW: packed destination register index, same packing.
- `gnt` output NREQ: one-hot current bus owner; all zero when idle.
- `ack` output NREQ: one-cycle completion pulse to the owner.
- `err` output 1: one-cycle pulse with `ack` when the captured index was out of range.
- `tri_controller_OH` output NSEL: one-hot bus driver select.
- `r_en_OH` output NSEL: one-hot register write enable.
- `busy` output 1: high in DRIVE and WRITE.

## Operation
- FSM states: IDLE, DRIVE, WRITE.
- **IDLE**
  - If any `req` is high, pick a winner round-robin, starting at the requester after the last winner.
  - Capture the winner's `src_idx` and `dst_idx`, set `gnt`, go to DRIVE.
- **DRIVE**
  - `tri_controller_OH` = onehot(src); `r_en_OH` = 0. The bus settles this cycle.
  - Go to WRITE.
- **WRITE**
  - `tri_controller_OH` = onehot(src); `r_en_OH` = onehot(dst); `ack[owner]` = 1.
  - Re-arbitrate in the same cycle; the next state depends on the first case that applies:
    - Lock continuation: `lock[owner]` = 1, `req[owner]` = 1 and lock count < MAX_LOCK. The owner keeps the bus, its indices are recaptured, the lock count increments, and the FSM goes to DRIVE.
    - Otherwise, the owner's `req` is ignored this cycle. If another requester is pending, it wins by round-robin and the FSM goes to DRIVE with its indices captured, with no idle cycle. The round-robin pointer advances past the old owner.
    - If no other requester is pending, go to IDLE and clear `gnt`.
- The lock count resets to 1 on every new owner.
- Once MAX_LOCK transfers are reached, `lock` is ignored and the bus is handed on if any other request is pending. If none is pending, the FSM goes to IDLE; the same requester may then win again from IDLE.
- Indices are captured at grant. Changing `src_idx`/`dst_idx` or dropping `req` after grant does not abort or alter the transfer; it still completes and acks.
- An index ≥ NSEL is out of range. The transfer still runs and acks, `err` pulses, and the corresponding one-hot is forced to 0.
- `src` == `dst` is legal and needs no special handling.

## Timing
- All outputs are registered. Reset values: `gnt`=0, `ack`=0, `err`=0, `tri_controller_OH`=0, `r_en_OH`=0, `busy`=0, FSM=IDLE, round-robin pointer favouring requester 0, lock count 0.
- Latency: `req` high at edge N (in IDLE) → DRIVE and `gnt` at N+1 → WRITE and `ack` at N+2.
- Back-to-back throughput: one transfer per 2 cycles.
- At most one bit of `tri_controller_OH` and at most one bit of `r_en_OH` is high in any cycle.
- `r_en_OH` is non-zero only in WRITE.
- Asserting `rst_n` low in any state immediately zeroes all outputs; no partial write is issued afterwards.

## Structure
- Shared package `bus_arb_pkg`:
  - state enum (IDLE/DRIVE/WRITE);
  - constants NSEL_DEFAULT=20 and IDXW_DEFAULT=5;
  - an index-to-one-hot function with range check.
- One sub-module, `rr_picker`: combinational round-robin picker. Inputs: request vector, pointer, and an exclude mask. Outputs: one-hot winner and valid.

## Test plan
- Reset, then `req[2]`=1 with src=3, dst=7 → `gnt`=0100; `tri_controller_OH`=bit 3 at N+1 and N+2; `r_en_OH`=bit 7 only at N+2; `ack[2]` at N+2.
- `req`=1111 held with no lock → grant order 0,1,2,3,0; each transfer 2 cycles; no IDLE gaps.
- `req[1]` and `lock[1]` held with `req[0]` also high, MAX_LOCK=4 → four consecutive transfers to 1, then grant 0.
- Requester 0 with src=25 → `ack[0]` and `err` pulse together; `tri_controller_OH`=0 and `r_en_OH`=0 throughout.
- Requester 0 drops `req` and changes `dst_idx` one cycle after grant → original dst still written and acked.
- `rst_n` pulsed low during DRIVE → all outputs 0 asynchronously; after release, FSM in IDLE and requester 0 has highest priority.
